// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and schedule helper for the 2x2 matrix multiply sequencer.
package matmul_pkg;

    localparam int DATA_W     = 8;
    localparam int ACC_W      = 17;

    localparam int MM_PERIOD  = 5;
    localparam int MM_PH_P0   = 1;
    localparam int MM_PH_P1   = 4;
    localparam int MM_CAP_OFF = 6;
    localparam int MM_RUN_LEN = 21;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef logic [4:0] phase_t;

    // Phase value at which element e hits the given offset within its 5-cycle slot.
    function automatic phase_t mm_phase(input int e, input int off);
        return phase_t'(off + MM_PERIOD * e);
    endfunction

endpackage

// File: rtl/matmul_operand_rf.sv
// Operand register file: A00,A01,A10,A11 at 0..3, B00,B01,B10,B11 at 4..7.
// One synchronous write port, two combinational read ports.
module matmul_operand_rf
    import matmul_pkg::*;
(
    input  logic              CLK,
    input  logic              NRST,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [8];

    // NOTE: the file is reset entry by entry so a mid-run reset leaves no stale operands behind.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the 2x2 signed matrix multiplier: loads A/B, drives the 5-cycle operand
// schedule, captures the four dot products and drains them over a valid/ready port.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic              CLK,
    input  logic              NRST,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [2:0]        load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              go,
    output logic              busy,
    output logic              mm_start,
    output logic [DATA_W-1:0] mm_a,
    output logic [DATA_W-1:0] mm_b,
    input  logic [ACC_W-1:0]  mm_out,
    input  logic              mm_strobe,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_idx,
    output logic [ACC_W-1:0]  res_data,
    output logic              err
);

    state_t            state;
    phase_t            k;
    phase_t            k_next;
    logic [1:0]        idx;
    logic [ACC_W-1:0]  c_rf [4];
    logic              sel_p0;
    logic              sel_p1;
    logic              cap_hit;
    logic [1:0]        op_el;
    logic [1:0]        cap_el;
    logic [2:0]        raddr_a;
    logic [2:0]        raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    matmul_operand_rf u_operand_rf (
        .CLK     (CLK),
        .NRST    (NRST),
        .we      (load_valid & load_ready),
        .waddr   (load_addr),
        .wdata   (load_data),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    // Operands are decoded from the phase being entered so mm_a/mm_b can be registered.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        k_next  = (state == RUN) ? k + phase_t'(1) : '0;
        sel_p0  = 1'b0;
        sel_p1  = 1'b0;
        op_el   = '0;
        cap_hit = 1'b0;
        cap_el  = '0;
        for (int e = 0; e < 4; e++) begin
            if (k_next == mm_phase(e, MM_PH_P0)) begin
                sel_p0 = 1'b1;
                op_el  = 2'(e);
            end
            if (k_next == mm_phase(e, MM_PH_P1)) begin
                sel_p1 = 1'b1;
                op_el  = 2'(e);
            end
            if (k == mm_phase(e, MM_CAP_OFF)) begin
                cap_hit = 1'b1;
                cap_el  = 2'(e);
            end
        end
        // A[i][n] sits at 2i+n and B[n][j] at 4+2n+j; n selects the first or second product.
        raddr_a = {1'b0, op_el[1], sel_p1};
        raddr_b = {1'b1, sel_p1, op_el[0]};
    end

    // NOTE: sequential state uses <= so every register sees the pre-edge values of its peers.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state      <= IDLE;
            k          <= '0;
            idx        <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            res_valid  <= 1'b0;
            mm_start   <= 1'b0;
            mm_a       <= '0;
            mm_b       <= '0;
            for (int e = 0; e < 4; e++) c_rf[e] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state      <= RUN;
                        k          <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        mm_start   <= 1'b1;
                    end
                end
                RUN: begin
                    k        <= k_next;
                    mm_start <= (k_next < phase_t'(MM_RUN_LEN));
                    mm_a     <= (sel_p0 | sel_p1) ? rdata_a : '0;
                    mm_b     <= (sel_p0 | sel_p1) ? rdata_b : '0;
                    if (cap_hit) begin
                        c_rf[cap_el] <= mm_out;
                        if (!mm_strobe) err <= 1'b1;
                    end
                    if (k == phase_t'(MM_RUN_LEN)) begin
                        state     <= DRAIN;
                        idx       <= '0;
                        res_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state      <= IDLE;
                            res_valid  <= 1'b0;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_idx  = idx;
    assign res_data = c_rf[idx];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: behavioural multiplier and matrix model, per-cycle compare, scenario literals.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    logic              CLK = 1'b0;
    logic              NRST;
    logic              load_valid;
    logic              load_ready;
    logic [2:0]        load_addr;
    logic [DATA_W-1:0] load_data;
    logic              go;
    logic              busy;
    logic              mm_start;
    logic [DATA_W-1:0] mm_a;
    logic [DATA_W-1:0] mm_b;
    logic [ACC_W-1:0]  mm_out;
    logic              mm_strobe;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_idx;
    logic [ACC_W-1:0]  res_data;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;
    int start_cnt = 0;
    int strobe_kill_r = -1;

    always #5 CLK = ~CLK;

    matmul_sequencer dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .go         (go),
        .busy       (busy),
        .mm_start   (mm_start),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_out     (mm_out),
        .mm_strobe  (mm_strobe),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_idx    (res_idx),
        .res_data   (res_data),
        .err        (err)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Multiplier stand-in: counts cycles from the rising edge of mm_start, forms each dot
    // product from the operands seen at r=1+5e and r=4+5e, presents it with strobe at r=6+5e.
    int               fm_r;
    int               fm_cur;
    int               fm_e;
    bit               fm_prev;
    bit               fm_hit;
    int               fm_acc [4];
    logic [ACC_W-1:0] garbage;

    assign fm_cur    = (mm_start && !fm_prev) ? 0 : fm_r;
    assign fm_hit    = (fm_r >= 6) && (fm_r <= 21) && ((fm_r - 6) % 5 == 0);
    assign fm_e      = fm_hit ? (fm_r - 6) / 5 : 0;
    assign mm_out    = fm_hit ? ACC_W'(fm_acc[fm_e]) : garbage;
    assign mm_strobe = fm_hit && (fm_r != strobe_kill_r);

    always @(posedge CLK) begin
        garbage <= ACC_W'($urandom);
        if (!NRST) begin
            fm_r    <= 99;
            fm_prev <= 1'b0;
        end else begin
            if (fm_cur % 5 == 1 && fm_cur <= 16)
                fm_acc[(fm_cur - 1) / 5] <= $signed(mm_a) * $signed(mm_b);
            if (fm_cur % 5 == 4 && fm_cur <= 19)
                fm_acc[(fm_cur - 4) / 5] <= fm_acc[(fm_cur - 4) / 5] + $signed(mm_a) * $signed(mm_b);
            fm_r    <= (fm_cur < 99) ? fm_cur + 1 : 99;
            fm_prev <= mm_start;
        end
    end

    // Reference model: mode 0 idle, 1 run (t = cycles since go), 2 drain (m_idx).
    int                       m_mode;
    int                       m_t;
    int                       m_idx;
    bit                       m_err;
    logic signed [DATA_W-1:0] m_reg [8];

    function automatic longint exp_c(input int e);
        return longint'(m_reg[2 * (e / 2)]) * m_reg[4 + e % 2]
             + longint'(m_reg[2 * (e / 2) + 1]) * m_reg[6 + e % 2];
    endfunction

    function automatic longint exp_mm(input bit is_b);
        int n;
        int e;
        if (m_mode != 1) return 0;
        if (m_t % 5 == 1 && m_t <= 16) n = 0;
        else if (m_t % 5 == 4 && m_t <= 19) n = 1;
        else return 0;
        e = (m_t - 1 - 3 * n) / 5;
        if (is_b) return m_reg[4 + 2 * n + e % 2];
        return m_reg[2 * (e / 2) + n];
    endfunction

    always @(posedge CLK) begin
        if (!NRST) begin
            m_mode <= 0;
            m_t    <= 0;
            m_idx  <= 0;
            m_err  <= 1'b0;
            for (int i = 0; i < 8; i++) m_reg[i] <= '0;
        end else begin
            case (m_mode)
                0: begin
                    if (load_valid) m_reg[load_addr] <= load_data;
                    if (go) begin
                        m_mode <= 1;
                        m_t    <= 0;
                        m_err  <= 1'b0;
                    end
                end
                1: begin
                    if (m_t >= 6 && (m_t - 6) % 5 == 0 && !mm_strobe) m_err <= 1'b1;
                    m_t <= m_t + 1;
                    if (m_t == 21) begin
                        m_mode <= 2;
                        m_idx  <= 0;
                    end
                end
                default: begin
                    if (res_ready) begin
                        if (m_idx == 3) m_mode <= 0;
                        m_idx <= (m_idx + 1) % 4;
                    end
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (mm_start) start_cnt++;
        if (cmp_en) begin
            check("load_ready", load_ready, m_mode == 0);
            check("busy", busy, m_mode != 0);
            check("mm_start", mm_start, m_mode == 1 && m_t <= 20);
            check("mm_a", $signed(mm_a), exp_mm(1'b0));
            check("mm_b", $signed(mm_b), exp_mm(1'b1));
            check("res_valid", res_valid, m_mode == 2);
            check("err", err, m_err);
            if (m_mode == 2) begin
                check("res_idx", res_idx, m_idx);
                check("res_data", $signed(res_data), exp_c(m_idx));
            end
        end
    end

    task automatic pulse_go();
        go = 1'b1;
        @(posedge CLK); #1;
        go = 1'b0;
    endtask

    task automatic load_all(input int a[4], input int b[4], input bit fuse_go);
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                go = 1'b0;
                @(posedge CLK); #1;
            end
            load_valid = 1'b1;
            load_addr  = 3'(n);
            load_data  = (n < 4) ? DATA_W'(a[n]) : DATA_W'(b[n - 4]);
            go         = fuse_go && (n == 7);
            @(posedge CLK); #1;
        end
        load_valid = 1'b0;
        go = 1'b0;
    endtask

    task automatic collect(output longint r[4], input int stall_idx, input int stall_n, input bit rnd);
        int guard = 0;
        int got = 0;
        int stall = 0;
        res_ready = 1'b0;
        while (got < 4 && guard < 300) begin
            @(negedge CLK);
            guard++;
            res_ready = 1'b0;
            if (res_valid) begin
                if (res_idx == 2'(stall_idx) && stall < stall_n) begin
                    stall++;
                end else if (!rnd || $urandom_range(0, 2) != 0) begin
                    check("res_order", res_idx, got);
                    r[res_idx] = $signed(res_data);
                    res_ready = 1'b1;
                    got++;
                end
            end
        end
        check("collect_done", got, 4);
        @(posedge CLK); #1;
        res_ready = 1'b0;
    endtask

    function automatic longint dot(input int a[4], input int b[4], input int e);
        return a[2 * (e / 2)] * b[e % 2] + a[2 * (e / 2) + 1] * b[2 + e % 2];
    endfunction

    initial begin
        longint r [4];
        int     a [4];
        int     b [4];
        int     s1 [4] = '{19, 22, 43, 50};

        NRST = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
        go = 1'b0; res_ready = 1'b0;
        @(posedge CLK); #1;
        cmp_en = 1'b1;
        check("rst_mm_start", mm_start, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err", err, 0);
        check("rst_mm_a", mm_a, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_load_ready", load_ready, 1);
        @(posedge CLK); #1;
        NRST = 1'b1;

        // Basic product, mm_start length.
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        load_all(a, b, 1'b0);
        start_cnt = 0;
        pulse_go();
        collect(r, -1, 0, 1'b0);
        for (int e = 0; e < 4; e++) check("s1_result", r[e], s1[e]);
        check("s1_start_cycles", start_cnt, 21);
        check("s1_err", err, 0);

        // Backpressure at idx 1, operands persisting from the previous run.
        pulse_go();
        collect(r, 1, 5, 1'b0);
        for (int e = 0; e < 4; e++) check("s3_result", r[e], s1[e]);

        // Range extremes.
        a = '{-128, -128, -128, -128};
        b = '{-128, -128, -128, -128};
        load_all(a, b, 1'b1);
        collect(r, -1, 0, 1'b0);
        for (int e = 0; e < 4; e++) check("s2_max", r[e], 32768);
        b = '{127, 127, 127, 127};
        load_all(a, b, 1'b1);
        collect(r, -1, 0, 1'b0);
        for (int e = 0; e < 4; e++) check("s2_min", r[e], -32512);

        // go and a load attempted mid-run are ignored.
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        load_all(a, b, 1'b0);
        pulse_go();
        repeat (3) @(posedge CLK);
        #1;
        load_valid = 1'b1; load_addr = 3'd0; load_data = 8'd99; go = 1'b1;
        check("s4_load_ready", load_ready, 0);
        @(posedge CLK); #1;
        load_valid = 1'b0; go = 1'b0;
        collect(r, -1, 0, 1'b0);
        for (int e = 0; e < 4; e++) check("s4_result", r[e], s1[e]);

        // Reset at k=10.
        pulse_go();
        repeat (10) @(posedge CLK);
        #1;
        NRST = 1'b0;
        @(posedge CLK); #1;
        check("s5_mm_start", mm_start, 0);
        check("s5_busy", busy, 0);
        check("s5_res_valid", res_valid, 0);
        check("s5_c_cleared", res_data, 0);
        NRST = 1'b1;
        pulse_go();
        collect(r, -1, 0, 1'b0);
        for (int e = 0; e < 4; e++) check("s5_zero_regs", r[e], 0);
        for (int i = 0; i < 4; i++) begin
            a[i] = int'($urandom_range(0, 255)) - 128;
            b[i] = int'($urandom_range(0, 255)) - 128;
        end
        load_all(a, b, 1'b1);
        collect(r, -1, 0, 1'b1);
        for (int e = 0; e < 4; e++) check("s5_result", r[e], dot(a, b, e));

        // Missing strobe at k=11.
        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        load_all(a, b, 1'b0);
        strobe_kill_r = 11;
        pulse_go();
        repeat (11) @(posedge CLK);
        @(negedge CLK);
        check("s6_err_k11", err, 0);
        @(negedge CLK);
        check("s6_err_k12", err, 1);
        collect(r, -1, 0, 1'b0);
        for (int e = 0; e < 4; e++) check("s6_result", r[e], s1[e]);
        check("s6_err_held", err, 1);
        strobe_kill_r = -1;
        pulse_go();
        @(negedge CLK);
        check("s6_err_cleared", err, 0);
        collect(r, -1, 0, 1'b0);

        // Randomized operands and backpressure.
        for (int it = 0; it < 8; it++) begin
            bit fuse;
            for (int i = 0; i < 4; i++) begin
                a[i] = int'($urandom_range(0, 255)) - 128;
                b[i] = int'($urandom_range(0, 255)) - 128;
            end
            fuse = 1'($urandom_range(0, 1));
            load_all(a, b, fuse);
            if (!fuse) pulse_go();
            collect(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b1);
            for (int e = 0; e < 4; e++) check("rand_result", r[e], dot(a, b, e));
        end

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not finish in time");
    end

endmodule
